// File: rtl/hssaer_dec.sv
// HSSAER receive decoder: NRZI-decodes two DDR line samples per clock and
// frames the transition stream into dsize-bit words, keepalives and errors.
module hssaer_dec #(
  parameter int dsize = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       rxd,
  input  logic             en,
  output logic [dsize-1:0] dout,
  output logic             dvalid,
  output logic             alive,
  output logic             ferr,
  output logic             busy,
  output logic [7:0]       ferr_cnt
);

  localparam int CW = $clog2(dsize + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0]       state, state_n;
  logic             prev;
  logic [dsize-1:0] sr, sr_n, word;
  logic [CW-1:0]    cnt, cnt_n;
  logic             t1, t0, bit_v;
  logic             good, keep, err;

  assign t1   = rxd[1] ^ prev;
  assign t0   = rxd[0] ^ rxd[1];
  assign busy = (state != IDLE);

  // Two unrolled framing steps per clock: t1 first, then t0. The word is
  // captured at the stop bit so a start bit in the same clock cannot clobber it.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    word    = sr;
    good    = 1'b0;
    keep    = 1'b0;
    err     = 1'b0;
    bit_v   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bit_v = (i == 0) ? t1 : t0;
      case (state_n)
        IDLE: begin
          if (bit_v) begin
            state_n = DATA;
            sr_n    = '0;
            cnt_n   = '0;
          end
        end
        DATA: begin
          if (dsize > 1) sr_n = {sr_n[dsize-2:0], bit_v};
          else           sr_n = bit_v;
          cnt_n = cnt_n + CW'(1);
          if (cnt_n == CW'(dsize)) state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          word    = sr_n;
          if (bit_v)           good = 1'b1;
          else if (sr_n == '0) keep = 1'b1;
          else                 err  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
    if (!en) begin
      state_n = IDLE;
      good    = 1'b0;
      keep    = 1'b0;
      err     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prev     <= 1'b0;
      sr       <= '0;
      cnt      <= '0;
      dout     <= '0;
      dvalid   <= 1'b0;
      alive    <= 1'b0;
      ferr     <= 1'b0;
      ferr_cnt <= 8'd0;
    end else begin
      prev   <= rxd[0];
      state  <= state_n;
      sr     <= sr_n;
      cnt    <= cnt_n;
      dvalid <= good;
      alive  <= keep;
      ferr   <= err;
      if (good) dout <= word;
      if (err && ferr_cnt != 8'hFF) ferr_cnt <= ferr_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_hssaer_dec.sv
// Self-checking bench for hssaer_dec: directed frames plus random traffic,
// compared every cycle against a bit-queue frame model.
module tb_hssaer_dec;

  localparam int DSIZE = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       rxd = 2'b00;
  logic             en  = 1'b0;
  logic [DSIZE-1:0] dout;
  logic             dvalid, alive, ferr, busy;
  logic [7:0]       ferr_cnt;

  hssaer_dec #(.dsize(DSIZE)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .en(en),
    .dout(dout), .dvalid(dvalid), .alive(alive), .ferr(ferr),
    .busy(busy), .ferr_cnt(ferr_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: the frame is just the list of bits seen after a start bit.
  bit               m_in_frame;
  bit               m_q[$];
  logic [DSIZE-1:0] m_dout;
  logic             m_dv, m_al, m_fe;
  int               m_fcnt;

  logic line_level;
  bit   bq[$];
  bit   chk_on = 1'b0;
  int   cyc = 0;
  int   dv_seen = 0, al_seen = 0, fe_seen = 0;
  int   last_dv_cyc = 0, prev_dv_cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_in_frame = 1'b0;
    m_q.delete();
    m_dout = '0;
    m_dv = 1'b0; m_al = 1'b0; m_fe = 1'b0;
    m_fcnt = 0;
  endtask

  task automatic modelBit(input bit b);
    logic [DSIZE-1:0] w;
    if (!m_in_frame) begin
      if (b) begin
        m_in_frame = 1'b1;
        m_q.delete();
      end
    end else begin
      m_q.push_back(b);
      if (m_q.size() == DSIZE + 1) begin
        w = '0;
        for (int k = 0; k < DSIZE; k++) w = {w[DSIZE-2:0], m_q[k]};
        m_in_frame = 1'b0;
        if (m_q[DSIZE]) begin
          m_dv = 1'b1; m_dout = w;
        end else if (w == '0) begin
          m_al = 1'b1;
        end else begin
          m_fe = 1'b1;
          if (m_fcnt < 255) m_fcnt++;
        end
      end
    end
  endtask

  task automatic modelStep(input bit b1, input bit b0, input bit e);
    m_dv = 1'b0; m_al = 1'b0; m_fe = 1'b0;
    if (!e) begin
      m_in_frame = 1'b0;
    end else begin
      modelBit(b1);
      modelBit(b0);
    end
  endtask

  // Single compare process: checks every output against the model each cycle.
  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      checkOutput("dvalid",   32'(dvalid),   32'(m_dv));
      checkOutput("alive",    32'(alive),    32'(m_al));
      checkOutput("ferr",     32'(ferr),     32'(m_fe));
      checkOutput("busy",     32'(busy),     32'(m_in_frame));
      checkOutput("dout",     32'(dout),     32'(m_dout));
      checkOutput("ferr_cnt", 32'(ferr_cnt), 32'(m_fcnt));
      if (dvalid) begin
        dv_seen++;
        prev_dv_cyc = last_dv_cyc;
        last_dv_cyc = cyc;
      end
      if (alive) al_seen++;
      if (ferr)  fe_seen++;
    end
  end

  // One clock of line activity: encode the two logical bits as NRZI levels.
  task automatic applyStimulus(input bit b1, input bit b0, input bit e);
    logic l1, l0;
    l1 = line_level ^ b1;
    l0 = l1 ^ b0;
    line_level = l0;
    rxd = {l1, l0};
    en  = e;
    @(posedge clk);
    modelStep(b1, b0, e);
    @(negedge clk);
  endtask

  task automatic pushFrame(input logic [DSIZE-1:0] w, input bit stop);
    bq.push_back(1'b1);
    for (int k = DSIZE - 1; k >= 0; k--) bq.push_back(w[k]);
    bq.push_back(stop);
  endtask

  task automatic runBits(input bit e);
    bit a, b;
    if (bq.size() % 2 != 0) bq.push_back(1'b0);
    while (bq.size() >= 2) begin
      a = bq.pop_front();
      b = bq.pop_front();
      applyStimulus(a, b, e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic resetDut();
    chk_on = 1'b0;
    rst = 1'b1;
    en = 1'b0;
    rxd = 2'b00;
    line_level = 1'b0;
    bq.delete();
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
  endtask

  initial begin
    int d0, a0, f0, r;
    resetDut();
    checkOutput("reset_dout", 32'(dout), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);

    // Constant line level: no transitions, nothing happens.
    idle(20);
    checkOutput("quiet_pulses", 32'(dv_seen + al_seen + fe_seen), 32'd0);

    // 0xA5 frame with start on t1.
    d0 = dv_seen;
    pushFrame(8'hA5, 1'b1);
    runBits(1'b1);
    idle(2);
    checkOutput("a5_count", 32'(dv_seen - d0), 32'd1);
    checkOutput("a5_dout", 32'(dout), 32'hA5);
    checkOutput("a5_model", 32'(m_dout), 32'hA5);
    checkOutput("a5_ferrcnt", 32'(ferr_cnt), 32'd0);

    // Start on t0, then a back-to-back 0x3C frame.
    d0 = dv_seen;
    bq.push_back(1'b0);
    pushFrame(8'hA5, 1'b1);
    pushFrame(8'h3C, 1'b1);
    runBits(1'b1);
    idle(2);
    checkOutput("b2b_count", 32'(dv_seen - d0), 32'd2);
    checkOutput("b2b_gap", 32'(last_dv_cyc - prev_dv_cyc), 32'd5);
    checkOutput("b2b_dout", 32'(dout), 32'h3C);

    // Keepalive leaves dout alone.
    a0 = al_seen; d0 = dv_seen;
    pushFrame(8'h00, 1'b0);
    runBits(1'b1);
    idle(2);
    checkOutput("ka_count", 32'(al_seen - a0), 32'd1);
    checkOutput("ka_nodv", 32'(dv_seen - d0), 32'd0);
    checkOutput("ka_dout", 32'(dout), 32'h3C);

    // Framing errors, then saturation of the counter.
    f0 = fe_seen;
    pushFrame(8'h01, 1'b0);
    runBits(1'b1);
    idle(1);
    checkOutput("fe_count", 32'(fe_seen - f0), 32'd1);
    checkOutput("fe_cnt1", 32'(ferr_cnt), 32'd1);
    for (int k = 0; k < 299; k++) begin
      pushFrame(8'h01, 1'b0);
      runBits(1'b1);
    end
    idle(1);
    checkOutput("fe_sat", 32'(ferr_cnt), 32'd255);
    checkOutput("fe_dout", 32'(dout), 32'h3C);

    // en dropped mid-frame discards it silently; next frame decodes.
    d0 = dv_seen; a0 = al_seen; f0 = fe_seen;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idle(3);
    checkOutput("en_nopulse", 32'((dv_seen - d0) + (al_seen - a0) + (fe_seen - f0)), 32'd0);
    pushFrame(8'h5A, 1'b1);
    runBits(1'b1);
    idle(2);
    checkOutput("en_5a_count", 32'(dv_seen - d0), 32'd1);
    checkOutput("en_5a_dout", 32'(dout), 32'h5A);

    // Reset asserted mid-frame clears everything asynchronously.
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    chk_on = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_dout", 32'(dout), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_fcnt", 32'(ferr_cnt), 32'h0);
    checkOutput("rst_pulses", 32'({dvalid, alive, ferr}), 32'h0);
    resetDut();
    idle(4);

    // Random traffic: good frames, keepalives, noise, idle and en drops.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 5);
      case (r)
        0, 1: pushFrame(DSIZE'($urandom_range(0, 255)), 1'b1);
        2:    pushFrame(8'h00, 1'b0);
        3:    for (int k = 0; k < 10; k++) bq.push_back(1'($urandom_range(0, 1)));
        4:    for (int k = 0; k < $urandom_range(1, 4); k++) bq.push_back(1'b0);
        default: ;
      endcase
      if (r == 5) begin
        for (int k = 0; k < 2; k++)
          applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        runBits(1'b1);
      end
    end
    idle(12);
    checkOutput("rand_idle_busy", 32'(busy), 32'h0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
